t11_bus_responder: RTL
======================

// Module: t11_bus_responder
//
// PURPOSE
//   Target-side end of the T11 core bus. Decodes addr/dout/wr_n from the core, serves reads from
//   on-chip word RAM, posts I/O-page writes into a FIFO drained over a valid/ready port, and drives
//   the boot mode word on din while reset is high, so the core latches MR at power-up.
//
// PARAMETERS
//   RAM_AW     10        RAM word-address width; RAM spans bytes 0 .. 2*2**RAM_AW-1
//   IO_BASE    16'hFF00  first byte address of the I/O page (IO_BASE .. 16'hFFFF)
//   MODE_WORD  16'h0000  value driven on cpu_din during reset (core MR; bits 15:13 select start PC)
//   FIFO_AW    2         log2 of I/O write FIFO depth (default depth 4)
//   WP_LIMIT   16'h0000  write-protect bound (used only with T11_RESP_WRPROT_EN)
//
// PORTS
//   clk        in   1   clock
//   reset      in   1   synchronous, active-high reset
//   cpu_addr   in   16  core byte address; 16'h0000 while the core is not accessing
//   cpu_dout   in   16  core write data
//   cpu_wr_n   in   1   0 = write this cycle
//   cpu_din    out  16  read data / mode word to core
//   io_valid   out  1   FIFO head valid
//   io_ready   in   1   consumer accepts head
//   io_addr    out  16  head byte address
//   io_data    out  16  head write data
//
// BEHAVIOUR
//   - Decode: RAM hit = cpu_addr < 2*2**RAM_AW, word index cpu_addr[RAM_AW:1]; bit 0 ignored.
//     I/O hit = cpu_addr >= IO_BASE. Status reg STAT at IO_BASE+16'h00FE. Else unmapped.
//   - Writes (cpu_wr_n=0), committed at the rising edge: RAM hit -> full word written.
//     STAT -> clears sticky flags, not queued. Other I/O -> push {cpu_addr,cpu_dout}.
//     Unmapped -> ignored. The core has no byte strobes; all writes are 16-bit.
//   - Reads: performed every non-reset cycle. rdata_q <= RAM[idx], STAT, or 16'h0000 if unmapped.
//     I/O non-STAT reads return 16'h0000. One cycle latency: cpu_din in cycle n+1 = data for the
//     addr of cycle n. Read-during-write to the same RAM word returns the OLD word.
//   - cpu_din = reset ? MODE_WORD : rdata_q. Combinational mux, so MR is valid on every reset edge.
//   - STAT = {ovf, wpv, 6'd0, count[7:0]}. count = FIFO occupancy, zero-extended.
//   - FIFO: circular, 2**FIFO_AW entries, pointers wrap modulo depth, count of FIFO_AW+1 bits.
//     io_valid = (count != 0). io_addr/io_data = head entry. Pop when io_valid & io_ready.
//     A push is accepted if count < depth, or if a pop happens the same cycle (full + push + pop
//     -> count unchanged). A push to a full FIFO with no pop is dropped and sets ovf (sticky).
//     On an empty FIFO, push + pop cannot coincide because io_valid=0.
//     Head entry and io_valid must stay stable until popped.
//   - A STAT write and a flag-setting event in the same cycle: the set wins.
//   - Reset (any cycle, including mid-drain): FIFO emptied, pointers=0, io_valid=0, ovf=wpv=0,
//     rdata_q=0, io_addr/io_data=0. RAM contents are NOT cleared.
//   - No state machine beyond the FIFO. All outputs are registered, except the cpu_din reset mux
//     and the io_* head-read outputs.
//
// CONFIGURATION
//   T11_RESP_WRPROT_EN defined: RAM writes with cpu_addr < WP_LIMIT are suppressed and set wpv
//     (STAT[14], sticky, cleared by a STAT write). Reads are unaffected.
//   Not defined: no protection logic; wpv is tied to 0 and WP_LIMIT is ignored.
//
// TESTING
//   1 reset=1, MODE_WORD=16'hC000 -> cpu_din=16'hC000 each reset cycle; after release,
//     io_valid=0 and the STAT read gives 16'h0000.
//   2 write 16'h1234 @16'h0010, next cycle read @16'h0010 -> cpu_din=16'h1234 one cycle later;
//     read @16'h0011 gives the same word.
//   3 io_ready=0, five writes to @16'hFF10 data 1..5 -> count=4, ovf=1, STAT=16'h8004.
//     Raise io_ready -> pops 1,2,3,4 in order, then io_valid=0.
//   4 FIFO full + write @16'hFF20 + io_ready=1 same cycle -> count stays 4, new entry at tail, ovf
//     unchanged. Write STAT -> ovf cleared.
//   5 assert reset with 3 queued entries -> next cycle io_valid=0, count=0. RAM word written before
//     reset still reads back.
//   6 (WRPROT_EN, WP_LIMIT=16'h0100) write @16'h0080 -> RAM unchanged, STAT[14]=1.
//     Write @16'h0100 -> stored.

Source files
------------

// File: rtl/t11_bus_responder.sv
// t11_bus_responder: target side of the T11 core bus.
// Serves reads from on-chip word RAM, queues I/O-page writes into a small FIFO
// drained over a valid/ready port, and presents the boot mode word on cpu_din
// while reset is high so the core latches MR.
// Optional feature macro: T11_RESP_WRPROT_EN (RAM write protection below WP_LIMIT).
module t11_bus_responder #(
    parameter int          RAM_AW    = 10,
    parameter logic [15:0] IO_BASE   = 16'hFF00,
    parameter logic [15:0] MODE_WORD = 16'h0000,
    parameter int          FIFO_AW   = 2,
    parameter logic [15:0] WP_LIMIT  = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    input  logic        cpu_wr_n,
    output logic [15:0] cpu_din,
    output logic        io_valid,
    input  logic        io_ready,
    output logic [15:0] io_addr,
    output logic [15:0] io_data
);

    localparam int               DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_CNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [16:0]      RAM_BYTES = 17'd2 << RAM_AW;
    localparam logic [15:0]      STAT_ADDR = IO_BASE + 16'h00FE;

    logic [15:0]        mem_q [2**RAM_AW];
    logic [15:0]        fifo_addr_q [DEPTH];
    logic [15:0]        fifo_data_q [DEPTH];

    logic               ram_hit, io_hit, stat_hit, is_wr;
    logic               ram_we, push, pop, push_ok, push_drop, stat_clr, wp_block;
    logic [RAM_AW-1:0]  ram_idx;
    logic [15:0]        stat_w;
    logic [15:0]        rdata_q, rdata_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               wpv;

`ifdef T11_RESP_WRPROT_EN
    logic wpv_q;

    // Only RAM writes below the protection bound are blocked; reads are untouched.
    always_comb begin
        wp_block = ram_hit && (cpu_addr < WP_LIMIT);
    end

    // Sticky write-protect violation flag; a new violation beats a STAT clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            wpv_q <= 1'b0;
        end else begin
            wpv_q <= (wpv_q & ~stat_clr) | (is_wr & wp_block);
        end
    end

    assign wpv = wpv_q;
`else
    logic unused_wp;

    assign wp_block  = 1'b0;
    assign wpv       = 1'b0;
    assign unused_wp = ^WP_LIMIT;
`endif

    // Address decode and per-cycle FIFO/flag control; RAM takes priority over the I/O page.
    always_comb begin
        ram_hit   = ({1'b0, cpu_addr} < RAM_BYTES);
        io_hit    = !ram_hit && (cpu_addr >= IO_BASE);
        stat_hit  = io_hit && (cpu_addr == STAT_ADDR);
        ram_idx   = cpu_addr[RAM_AW:1];
        is_wr     = !cpu_wr_n && !reset;

        ram_we    = is_wr && ram_hit && !wp_block;
        push      = is_wr && io_hit && !stat_hit;
        pop       = (count_q != '0) && io_ready;
        push_ok   = push && ((count_q < DEPTH_CNT) || pop);
        push_drop = push && !push_ok;
        stat_clr  = is_wr && stat_hit;

        stat_w    = {ovf_q, wpv, 6'd0, 8'(count_q)};

        rdata_d   = 16'h0000;
        if (ram_hit) begin
            rdata_d = mem_q[ram_idx];
        end else if (stat_hit) begin
            rdata_d = stat_w;
        end

        wr_ptr_d  = wr_ptr_q + FIFO_AW'(push_ok);
        rd_ptr_d  = rd_ptr_q + FIFO_AW'(pop);
        count_d   = count_q + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop);
        ovf_d     = (ovf_q && !stat_clr) || push_drop;
    end

    // Word RAM: no reset so contents survive a core reset; reads see the pre-write word.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ram_idx] <= cpu_dout;
        end
    end

    // Read-data register, FIFO pointers/occupancy and the overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q  <= 16'h0000;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; cleared on reset so the head outputs read zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= 16'h0000;
                fifo_data_q[i] <= 16'h0000;
            end
        end else if (push_ok) begin
            fifo_addr_q[wr_ptr_q] <= cpu_addr;
            fifo_data_q[wr_ptr_q] <= cpu_dout;
        end
    end

    assign cpu_din  = reset ? MODE_WORD : rdata_q;
    assign io_valid = (count_q != '0);
    assign io_addr  = fifo_addr_q[rd_ptr_q];
    assign io_data  = fifo_data_q[rd_ptr_q];

endmodule
